router_fifo: RTL
================

Name: router_fifo

Overview:
- Per-destination output buffer of the 1x3 router: one instance per output port (three total), sitting directly downstream of the register stage.
- Accepts bytes from the register stage's dout when the synchroniser asserts write_enb, tagging each header byte with the lfd_state flag.
- Serves bytes to the destination on read_enb and tracks packet boundaries on the read side.
- Supports a soft-reset flush when the destination times out.

Parameters:
- DATA_WIDTH, 8, byte width of stored data (stored word is DATA_WIDTH+1 incl. header flag)
- DEPTH, 16, number of entries; power of two
- ADDR_WIDTH, 4, log2(DEPTH)

Ports:
- clock  in  1  single system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- soft_reset  in  1  synchronous flush request from synchroniser (timeout)
- write_enb  in  1  write request
- read_enb  in  1  read request from destination
- lfd_state  in  1  marks current write as header byte
- data_in  in  DATA_WIDTH  byte from register stage
- data_out  out  DATA_WIDTH  registered read data
- full  out  1  no free entry
- empty  out  1  no stored entry
- fill_level  out  ADDR_WIDTH+1  occupied entries, 0..DEPTH
- pkt_done  out  1  one-cycle pulse when a packet's parity byte is read

Behaviour:
- Reset:
  - resetn low asynchronously clears wr_ptr, rd_ptr, byte counter, data_out=0, pkt_done=0.
  - Outputs after reset: empty=1, full=0, fill_level=0.
  - Memory contents need not be cleared.
- Pointers and flags:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr==rd_ptr).
  - full = addresses equal and wrap bits differ.
  - fill_level = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
  - All three are combinational from registered pointers, so flags change on the edge after the causing write/read.
- Write:
  - Occurs when write_enb && !full.
  - mem[wr_ptr[ADDR_WIDTH-1:0]] <= {lfd_state, data_in}; wr_ptr increments.
  - Write while full is dropped silently; pointers unchanged.
- Read:
  - Occurs when read_enb && !empty.
  - data_out <= mem[rd_ptr][DATA_WIDTH-1:0] on that edge (1-cycle latency); rd_ptr increments.
  - Read while empty: data_out holds, pointers unchanged.
- Simultaneous read and write:
  - Both proceed when neither is blocked; fill_level unchanged.
  - When full, only the read proceeds; the write is dropped.
  - When empty, only the write proceeds; data_out is not updated that cycle (no fall-through).
- Packet tracking (read side):
  - byte_cnt is 7 bits.
  - On a read of a word with the header flag set: byte_cnt <= data[7:2] + 1, i.e. payload length plus parity.
  - On a read of a non-header word with byte_cnt>0: byte_cnt decrements.
  - pkt_done pulses for one cycle when byte_cnt goes 1->0, aligned with data_out showing the parity byte.
  - A header read while byte_cnt != 0 reloads byte_cnt (the new packet wins); no pkt_done for the truncated packet.
  - A non-header read with byte_cnt==0 leaves the count at 0 and produces no pulse.
- Soft reset:
  - On an edge with soft_reset=1: pointers, byte_cnt and data_out clear to 0, and pkt_done=0.
  - soft_reset overrides any read/write in the same cycle.
- Wrap-around: pointers wrap naturally modulo 2^(ADDR_WIDTH+1); no special casing.
- Reset mid-operation: resetn low at any time returns all state to reset values immediately; a partially read packet is discarded.

Decomposition:
- Shared router package holds:
  - ROUTER_DATA_WIDTH=8
  - ROUTER_FIFO_DEPTH=16
  - header field positions: ADDR field [1:0], LEN field [7:2]
  - port-address constants 2'b00/01/10
- One natural sub-module: router_fifo_mem, a DEPTH x (DATA_WIDTH+1) register array with one synchronous write port and one registered read port.
- Pointers, flags and byte counter stay in router_fifo.

Test Plan:
- Reset/basic:
  - Release resetn, write header 8'h0C (len 3, lfd=1) then 8'hA1, 8'hA2, 8'hA3 and parity 8'h0C^A1^A2^A3.
  - Read five times.
  - Expect data_out = 0C, A1, A2, A3, parity; pkt_done high only with the parity byte; empty=1 at the end.
- Full boundary:
  - Write 17 bytes 8'h00..8'h10 with no reads.
  - Expect full=1 after the 16th, fill_level=16, 8'h10 dropped.
  - Reading 16 times returns 00..0F.
- Empty boundary:
  - With the FIFO empty, assert read_enb together with a write of 8'h55.
  - Expect data_out unchanged and fill_level=1; the next read returns 8'h55.
- Simultaneous read/write at full:
  - Fill with 16 bytes, then read_enb=write_enb=1 with data_in=8'hEE.
  - Expect one byte read, EE dropped, fill_level=15.
- Wrap-around:
  - Run 40 single-byte write-then-read pairs (values i).
  - Expect data_out=i each time; flags correct across pointer wrap.
- Soft reset:
  - Write 5 bytes, read 2, then pulse soft_reset concurrently with write_enb.
  - Expect empty=1, fill_level=0, data_out=0, no pkt_done.
  - A subsequent header 8'h04 plus 2 bytes reads correctly, with pkt_done on the 3rd read.

Source files
------------

// File: rtl/router_fifo_pkg.sv
// router_fifo_pkg: shared router constants, header field positions and port addresses.
//   ROUTER_DATA_WIDTH / ROUTER_FIFO_DEPTH : default byte width and buffer depth
//   ADDR_* / LEN_*                        : header byte fields (destination, payload length)
//   port_addr_e                           : destination port encodings
//   pkt_bytes()                           : bytes still to come after a header (payload + parity)
package router_fifo_pkg;
   localparam int ROUTER_DATA_WIDTH = 8;
   localparam int ROUTER_FIFO_DEPTH = 16;
   localparam int ADDR_LSB = 0;
   localparam int ADDR_MSB = 1;
   localparam int LEN_LSB = 2;
   localparam int LEN_MSB = 7;
   localparam int LEN_WIDTH = LEN_MSB - LEN_LSB + 1;
   localparam int CNT_WIDTH = 7;
   typedef enum logic [1:0] {
      PORT0 = 2'b00,
      PORT1 = 2'b01,
      PORT2 = 2'b10
   } port_addr_e;
   function automatic logic [CNT_WIDTH-1:0] pkt_bytes(input logic [LEN_WIDTH-1:0] len);
      return {1'b0, len} + 7'd1;
   endfunction
endpackage

// File: rtl/router_fifo_if.sv
// router_fifo_if: bundle between the synchroniser/register stage/destination and one output FIFO.
//   slave  : FIFO side (takes soft_reset, write_enb, read_enb, lfd_state, data_in;
//            drives data_out, full, empty, fill_level, pkt_done)
//   master : the surrounding router side, directions reversed
interface router_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  soft_reset;
   logic                  write_enb;
   logic                  read_enb;
   logic                  lfd_state;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;
   logic [ADDR_WIDTH:0]   fill_level;
   logic                  pkt_done;
   modport slave (
      input  soft_reset, write_enb, read_enb, lfd_state, data_in,
      output data_out, full, empty, fill_level, pkt_done
   );
   modport master (
      output soft_reset, write_enb, read_enb, lfd_state, data_in,
      input  data_out, full, empty, fill_level, pkt_done
   );
endinterface

// File: rtl/router_fifo_mem.sv
// router_fifo_mem: DEPTH x (DATA_WIDTH+1) storage, one synchronous write port, one registered read port.
//   clock, resetn     : clock and async active-low reset (read register only)
//   clr_i             : synchronous clear of the read register
//   we_i/waddr_i/wdata_i : write port, wdata_i = {header flag, byte}
//   re_i/raddr_i/rdata_o : registered read of the byte at raddr_i
//   rd_hdr_o/rd_len_o : header flag and length field of the word at raddr_i, seen before the read edge
module router_fifo_mem
   import router_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = ROUTER_DATA_WIDTH,
   parameter int DEPTH = ROUTER_FIFO_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  clr_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH:0]   wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rd_hdr_o,
   output logic [LEN_WIDTH-1:0]  rd_len_o
);
   logic [DATA_WIDTH:0]   mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clock)
      if (we_i) mem_q[waddr_i] <= wdata_i;

   always_ff @(posedge clock or negedge resetn)
      if (!resetn) rdata_q <= '0;
      else if (clr_i) rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i][DATA_WIDTH-1:0];

   assign rdata_o  = rdata_q;
   assign rd_hdr_o = mem_q[raddr_i][DATA_WIDTH];
   assign rd_len_o = mem_q[raddr_i][LEN_MSB:LEN_LSB];
endmodule

// File: rtl/router_fifo.sv
// router_fifo: per-destination output buffer of the 1x3 router with read-side packet tracking.
//   clock, resetn : clock and async active-low reset
//   bus (slave)   : write side (write_enb, lfd_state, data_in), read side (read_enb, data_out),
//                   status (full, empty, fill_level), pkt_done pulse, soft_reset flush
module router_fifo
   import router_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = ROUTER_DATA_WIDTH,
   parameter int DEPTH = ROUTER_FIFO_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic         clock,
   input  logic         resetn,
   router_fifo_if.slave bus
);
   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
   logic                 pkt_done_q, pkt_done_d;
   logic                 do_wr, do_rd, rd_hdr;
   logic [LEN_WIDTH-1:0] rd_len;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign bus.empty      = wr_ptr_q == rd_ptr_q;
   assign bus.full       = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                           (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
   assign bus.fill_level = wr_ptr_q - rd_ptr_q;
   assign bus.pkt_done   = pkt_done_q;

   always_comb begin
      do_wr      = bus.write_enb && !bus.full && !bus.soft_reset;
      do_rd      = bus.read_enb && !bus.empty && !bus.soft_reset;
      wr_ptr_d   = bus.soft_reset ? '0 : wr_ptr_q + PW'(do_wr);
      rd_ptr_d   = bus.soft_reset ? '0 : rd_ptr_q + PW'(do_rd);
      byte_cnt_d = byte_cnt_q;
      // A header always reloads the count, so a truncated packet never pulses.
      if (bus.soft_reset) byte_cnt_d = '0;
      else if (do_rd) byte_cnt_d = rd_hdr ? pkt_bytes(rd_len) :
                                   (byte_cnt_q != '0) ? byte_cnt_q - 1'b1 : '0;
      pkt_done_d = do_rd && !rd_hdr && byte_cnt_q == CNT_WIDTH'(1);
   end

   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         byte_cnt_q <= '0;
         pkt_done_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         byte_cnt_q <= byte_cnt_d;
         pkt_done_q <= pkt_done_d;
      end

   router_fifo_mem #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH(DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_mem (
      .clock   (clock),
      .resetn  (resetn),
      .clr_i   (bus.soft_reset),
      .we_i    (do_wr),
      .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wdata_i ({bus.lfd_state, bus.data_in}),
      .re_i    (do_rd),
      .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rdata_o (bus.data_out),
      .rd_hdr_o(rd_hdr),
      .rd_len_o(rd_len)
   );
endmodule
